// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with TXD and TXSTAT registers.
// Define UART_TX_FIFO_EN to replace the single holding slot with a 4-deep FIFO.
module uart_tx_periph #(
  parameter int unsigned BAUD_DIV  = 10417,
  parameter logic [31:0] TXD_ADDR  = 32'h4000_0018,
  parameter logic [31:0] STAT_ADDR = 32'h4000_0024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          tx_q;
  logic          irq_q;
  logic [7:0]    last_q;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic          irqen_q;

  logic       wr_txd, wr_stat;
  logic       tick, load, push, full, pend, busy;
  logic [7:0] head;
  logic [3:0] stat_hi;

  assign wr_txd  = MemWrite & (addr == TXD_ADDR);
  assign wr_stat = MemWrite & (addr == STAT_ADDR);
  assign tick    = (cnt_q == LAST);
  // The byte leaves the holding storage when a frame starts.
  assign load    = pend & ((state_q == IDLE) |
                           ((state_q == STOP) & tick));
  assign push    = wr_txd & ~full;
  assign busy    = (state_q != IDLE) | pend;

`ifdef UART_TX_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [1:0] wp_q, rp_q;
  logic [2:0] occ_q;

  assign pend    = (occ_q != 3'd0);
  assign full    = occ_q[2];
  assign head    = fifo_q[rp_q];
  assign stat_hi = {full, occ_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= 8'h00;
      wp_q  <= 2'd0;
      rp_q  <= 2'd0;
      occ_q <= 3'd0;
    end else begin
      if (push) begin
        fifo_q[wp_q] <= wdata[7:0];
        wp_q         <= wp_q + 2'd1;
      end
      if (load) rp_q <= rp_q + 2'd1;
      occ_q <= occ_q + {2'b0, push} - {2'b0, load};
    end
  end
`else
  logic [7:0] hold_q;
  logic       full_q;

  assign pend    = full_q;
  assign full    = full_q;
  assign head    = hold_q;
  assign stat_hi = 4'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= 8'h00;
      full_q <= 1'b0;
    end else if (push) begin
      hold_q <= wdata[7:0];
      full_q <= 1'b1;
    end else if (load) begin
      full_q <= 1'b0;
    end
  end
`endif

  // Set beats clear when both land in the same cycle.
  always_comb begin
    done_d = done_q;
    ovr_d  = ovr_q;
    if (wr_stat & wdata[1]) done_d = 1'b0;
    if (wr_stat & wdata[2]) ovr_d  = 1'b0;
    if ((state_q == STOP) & tick) done_d = 1'b1;
    if (wr_txd & full) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q  <= 8'h00;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      irqen_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_txd)  last_q  <= wdata[7:0];
      if (wr_stat) irqen_q <= wdata[3];
      done_q <= done_d;
      ovr_q  <= ovr_d;
      irq_q  <= irqen_q & done_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pend) begin
            state_q <= START;
            sh_q    <= head;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          cnt_q <= tick ? '0 : cnt_q + CW'(1);
          if (tick) begin
            state_q <= DATA;
            bit_q   <= 3'd0;
            tx_q    <= sh_q[0];
          end
        end
        DATA: begin
          cnt_q <= tick ? '0 : cnt_q + CW'(1);
          if (tick) begin
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              sh_q  <= sh_q >> 1;
              tx_q  <= sh_q[1];
            end
          end
        end
        STOP: begin
          cnt_q <= tick ? '0 : cnt_q + CW'(1);
          if (tick) begin
            if (pend) begin
              state_q <= START;
              sh_q    <= head;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (MemRead) begin
      if (addr == STAT_ADDR)
        rdata = {24'h0, stat_hi, irqen_q, ovr_q, done_q, busy};
      else if (addr == TXD_ADDR)
        rdata = {24'h0, last_q};
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^{wdata[31:8], wdata[0]};

  assign tx  = tx_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph (BAUD_DIV=16) with a serial-line
// decoder that pops expected bytes from a scoreboard queue.
module tb_uart_tx_periph;

  localparam int B = 16;
  localparam logic [31:0] TXD  = 32'h4000_0018;
  localparam logic [31:0] STAT = 32'h4000_0024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        MemWrite, MemRead;
  logic        tx, irq;

  uart_tx_periph #(.BAUD_DIV(B), .TXD_ADDR(TXD), .STAT_ADDR(STAT)) dut (
    .clk(clk), .reset(rst), .addr(addr), .wdata(wdata),
    .MemWrite(MemWrite), .MemRead(MemRead), .rdata(rdata),
    .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int nfr = 0;
  int fs [$];
  logic [7:0] exp_q [$];

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Serial decoder: 16 samples per bit slot, each slot must be steady.
  bit       mact = 0;
  int       ns, slot, fstart;
  logic     v, uni;
  logic [9:0] bits;
  always @(negedge clk) begin
    if (rst) begin
      mact = 0;
    end else begin
      if (!mact && tx === 1'b0) begin
        mact = 1; ns = 0; slot = 0; uni = 1; fstart = cyc;
      end
      if (mact) begin
        if (ns == 0) v = tx;
        else if (tx !== v) uni = 0;
        ns++;
        if (ns == B) begin
          bits[slot] = v;
          ns = 0;
          slot++;
          if (slot == 10) begin
            mact = 0;
            fs.push_back(fstart);
            if (exp_q.size() == 0) begin
              chk("unexpected_frame", {22'h0, bits}, 32'h0);
            end else begin
              logic [7:0] e;
              e = exp_q.pop_front();
              chk("frame", {21'h0, uni, bits}, {21'h0, 1'b1, 1'b1, e, 1'b0});
            end
            nfr++;
          end
        end
      end
    end
  end

  task automatic wr(logic [31:0] a, logic [31:0] d);
    addr = a; wdata = d; MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic rd(logic [31:0] a, output logic [31:0] d);
    addr = a; MemRead = 1'b1;
    #1 d = rdata;
    MemRead = 1'b0; addr = 32'h0;
  endtask

  task automatic wait_until(int c);
    int k = 0;
    while (cyc < c && k < 5000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_frames(int n);
    int k = 0;
    while (nfr < n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("frame_count", nfr, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int w, wa, s;
    rst = 1'b1; MemWrite = 1'b0; MemRead = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rd(STAT, r); chk("rst_stat", r, 32'h0);
    rd(TXD, r);  chk("rst_txd", r, 32'h0);
    rst = 1'b0;

    // single byte 0x55
    wait_until(9);
    exp_q.push_back(8'h55);
    wr(TXD, 32'h55); w = cyc;
    wait_until(60);
    rd(STAT, r); chk("stat_mid", r, 32'h1);
    MemRead = 1'b1; addr = 32'h1234_5678; #1;
    chk("rd_other", rdata, 32'h0);
    MemRead = 1'b0; addr = TXD; #1;
    chk("rd_gated", rdata, 32'h0);
    addr = 32'h0;
    wait_frames(1);
    chk("start_lat", fs[0] - w, 1);
    wait_until(fs[0] + 162);
    rd(STAT, r); chk("stat_done", r, 32'h2);
    chk("idle_tx", {31'h0, tx}, 32'h1);
    rd(TXD, r); chk("txd_last", r, 32'h55);

    // back-to-back 0xA3, 0x0F
    wr(STAT, 32'h2);
    rd(STAT, r); chk("clr_done", r, 32'h0);
    exp_q.push_back(8'hA3);
    wr(TXD, 32'hA3); wa = cyc;
    repeat (40) @(negedge clk);
    exp_q.push_back(8'h0F);
    wr(TXD, 32'h0F);
    rd(STAT, r); chk("stat_b2b_mid", r, 32'h1);
    wait_frames(3);
    chk("b2b_lat", fs[1] - wa, 1);
    chk("b2b_gap", fs[2] - fs[1], 10 * B);
    wait_until(fs[2] + 10 * B + 2);
    rd(STAT, r); chk("stat_b2b_end", r, 32'h2);

`ifndef UART_TX_FIFO_EN
    // overrun with single holding slot
    wr(STAT, 32'h2);
    exp_q.push_back(8'hA3);
    wr(TXD, 32'hA3);
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h5C);
    wr(TXD, 32'h5C);
    wr(TXD, 32'h77);
    rd(STAT, r); chk("stat_ovr", r, 32'h5);
    wait_frames(5);
    wait_until(fs[4] + 10 * B + 2);
    rd(STAT, r); chk("stat_ovr_end", r, 32'h6);
    rd(TXD, r); chk("txd_dropped", r, 32'h77);
    wr(STAT, 32'h4);
    rd(STAT, r); chk("clr_ovr", r, 32'h2);
`else
    // FIFO fill: first byte starts, next four fill, fifth overflows
    wr(STAT, 32'h2);
    exp_q.push_back(8'h10);
    wr(TXD, 32'h10);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(8'(8'h11 + i));
      wr(TXD, 32'h11 + i);
    end
    rd(STAT, r); chk("fifo_full", r, 32'hC5);
    wait_until(fs[2] + 10 * B + 1);
    rd(STAT, r); chk("fifo_occ3", r & 32'hF0, 32'h30);
    wait_frames(8);
    chk("fifo_gap", fs[7] - fs[3], 4 * 10 * B);
    wait_until(fs[7] + 10 * B + 2);
    rd(STAT, r); chk("fifo_end", r, 32'h6);
    wr(STAT, 32'h4);
    rd(STAT, r); chk("clr_ovr", r, 32'h2);
`endif

    // interrupt
    wr(STAT, 32'h2);
    wr(STAT, 32'h8);
    chk("irq_off", {31'h0, irq}, 32'h0);
    exp_q.push_back(8'h00);
    wr(TXD, 32'h0);
    wait_frames(nfr + 1);
    s = fs[$];
    wait_until(s + 10 * B);
    chk("irq_pre", {31'h0, irq}, 32'h0);
    rd(STAT, r); chk("stat_irq", r, 32'hA);
    wait_until(s + 10 * B + 1);
    chk("irq_rise", {31'h0, irq}, 32'h1);
    wr(STAT, 32'hA);
    @(negedge clk);
    chk("irq_drop", {31'h0, irq}, 32'h0);
    rd(STAT, r); chk("stat_irq_clr", r, 32'h8);

    // reset mid-frame
    exp_q.push_back(8'h3C);
    wr(TXD, 32'h3C); w = cyc;
    s = nfr;
    wait_until(w + 1 + 80);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", {31'h0, tx}, 32'h1);
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
    rd(STAT, r); chk("mid_rst_stat", r, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("no_resume", nfr, s);
    chk("post_rst_tx", {31'h0, tx}, 32'h1);
    chk("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
